// File: rtl/image_sdram_writer_if.sv
// SDRAM write-port bundle for image_sdram_writer.
// master drives req/addr/data and receives the ack pulse; slave is the controller side.
interface image_sdram_writer_if #(
  parameter int ADDR_W = 25
);
  logic              sdram_wr_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic [15:0]       sdram_data;
  logic              sdram_wr_ack;

  modport master (
    output sdram_wr_req,
    output sdram_addr,
    output sdram_data,
    input  sdram_wr_ack
  );

  modport slave (
    input  sdram_wr_req,
    input  sdram_addr,
    input  sdram_data,
    output sdram_wr_ack
  );
endinterface

// File: rtl/image_sdram_writer.sv
// Buffers ioctl download words in a small FIFO and commits them to SDRAM one at a time.
// Ports: clk, reset_n, ioctl_* download side, sdram (master bundle), status outputs.
// Macro IMAGE_WRITER_CHECKSUM_EN enables the 16-bit additive checksum; otherwise it is tied to 0.
module image_sdram_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 25
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ioctl_wr,
  input  logic [15:0]                 ioctl_dout,
  input  logic                        image_download,
  input  logic [25:0]                 base_addr,
  output logic                        ioctl_wait,
  image_sdram_writer_if.master        sdram,
  output logic                        download_done,
  output logic                        overflow,
  output logic [23:0]                 words_written,
  output logic [15:0]                 checksum
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + 16;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] WAIT_CNT = (PTR_W+1)'(FIFO_DEPTH - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_ACK = 2'd2;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    count;
  logic [1:0]        state;
  logic [ADDR_W-1:0] byte_addr;
  logic [ENT_W-1:0]  head;
  logic              full;
  logic              empty;
  logic              attempt;
  logic              push;
  logic              drop;
  logic              pop;
  logic              dl_q;
  logic              rise;
  logic              fall;
  logic              armed;
  logic              pending;

  // Extra pointer bit makes full (MSBs differ) distinct from empty.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_CNT);
  assign empty      = (wr_ptr == rd_ptr);
  assign ioctl_wait = (count >= WAIT_CNT);

  assign byte_addr = ADDR_W'({base_addr, 1'b0});
  assign attempt   = ioctl_wr & image_download;
  assign push      = attempt & ~full;
  assign drop      = attempt & full;
  assign pop       = (state == S_WAIT_ACK) & sdram.sdram_wr_ack;
  assign head      = mem[rd_ptr[PTR_W-1:0]];

  assign rise = image_download & ~dl_q;
  assign fall = ~image_download & dl_q;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[PTR_W-1:0]] <= {byte_addr, ioctl_dout};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      rd_ptr             <= '0;
      sdram.sdram_wr_req <= 1'b0;
      sdram.sdram_addr   <= '0;
      sdram.sdram_data   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!empty)
            state <= S_ISSUE;
        end
        S_ISSUE: begin
          sdram.sdram_addr   <= head[ENT_W-1:16];
          sdram.sdram_data   <= head[15:0];
          sdram.sdram_wr_req <= 1'b1;
          state              <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (sdram.sdram_wr_ack) begin
            sdram.sdram_wr_req <= 1'b0;
            rd_ptr             <= rd_ptr + 1'b1;
            state              <= S_IDLE;
          end
        end
        default: begin
          sdram.sdram_wr_req <= 1'b0;
          state              <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_written <= '0;
      overflow      <= 1'b0;
    end else if (rise) begin
      words_written <= '0;
      overflow      <= drop;
    end else begin
      if (pop && words_written != 24'hFFFFFF)
        words_written <= words_written + 24'd1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  // pending latches the end of download; done fires once the writer has drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q          <= 1'b0;
      armed         <= 1'b0;
      pending       <= 1'b0;
      download_done <= 1'b0;
    end else begin
      dl_q <= image_download;
      if (rise) begin
        armed         <= 1'b1;
        pending       <= 1'b0;
        download_done <= 1'b0;
      end else if (pending && empty && state == S_IDLE) begin
        armed         <= 1'b0;
        pending       <= 1'b0;
        download_done <= 1'b1;
      end else begin
        download_done <= 1'b0;
        if (fall && armed)
          pending <= 1'b1;
      end
    end
  end

`ifdef IMAGE_WRITER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      checksum <= '0;
    else if (rise)
      checksum <= push ? ioctl_dout : 16'h0000;
    else if (push)
      checksum <= checksum + ioctl_dout;
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_image_sdram_writer.sv
// Scoreboard bench for image_sdram_writer.
// Expected SDRAM writes are queued at push time and compared as the DUT issues them.
`timescale 1ns/1ps
module tb_image_sdram_writer;

  localparam int DEPTH = 4;
  localparam int AW    = 25;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_wr;
  logic [15:0] ioctl_dout;
  logic        image_download;
  logic [25:0] base_addr;
  logic        ioctl_wait;
  logic        download_done;
  logic        overflow;
  logic [23:0] words_written;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  image_sdram_writer_if #(.ADDR_W(AW)) sd ();

  image_sdram_writer #(
    .FIFO_DEPTH(DEPTH),
    .ADDR_W    (AW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ioctl_wr      (ioctl_wr),
    .ioctl_dout    (ioctl_dout),
    .image_download(image_download),
    .base_addr     (base_addr),
    .ioctl_wait    (ioctl_wait),
    .sdram         (sd.master),
    .download_done (download_done),
    .overflow      (overflow),
    .words_written (words_written),
    .checksum      (checksum)
  );

  int n_run;
  int n_fail;

  logic [AW+15:0] sb[$];
  int             m_occ;
  logic [15:0]    m_sum;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input logic [15:0] d, input logic [25:0] b);
    if (m_occ < DEPTH) begin
      sb.push_back({AW'({b, 1'b0}), d});
      m_occ++;
      m_sum += d;
    end
  endfunction

  task automatic push_word(input logic [15:0] d, input logic [25:0] b);
    ioctl_wr   = 1'b1;
    ioctl_dout = d;
    base_addr  = b;
    model_push(d, b);
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Waits (bounded) for a request, holds ack low for hold cycles, then acks.
  task automatic service(input int hold, output bit to,
                         output logic [AW-1:0] a, output logic [15:0] d);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (sd.sdram_wr_req === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    a = sd.sdram_addr;
    d = sd.sdram_data;
    if (!to) begin
      repeat (hold) tick();
      sd.sdram_wr_ack = 1'b1;
      tick();
      sd.sdram_wr_ack = 1'b0;
      m_occ--;
    end
  endtask

  task automatic start_dl();
    image_download = 1'b0;
    tick();
    image_download = 1'b1;
    tick();
    m_sum = 16'h0000;
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    ioctl_wr        = 1'b0;
    ioctl_dout      = '0;
    image_download  = 1'b0;
    base_addr       = '0;
    sd.sdram_wr_ack = 1'b0;
    m_occ           = 0;
    m_sum           = '0;
    #12;
    n_run++; if (sd.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", sd.sdram_wr_req); end
    n_run++; if (sd.sdram_addr !== '0) begin n_fail++; $display("FAIL rst_addr got %h want 0", sd.sdram_addr); end
    n_run++; if (sd.sdram_data !== '0) begin n_fail++; $display("FAIL rst_data got %h want 0", sd.sdram_data); end
    n_run++; if (download_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", download_done); end
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %b want 0", overflow); end
    n_run++; if (words_written !== 24'd0) begin n_fail++; $display("FAIL rst_words got %0d want 0", words_written); end
    n_run++; if (checksum !== 16'h0000) begin n_fail++; $display("FAIL rst_csum got %h want 0", checksum); end
    n_run++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL rst_wait got %b want 0", ioctl_wait); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int dones;
    start_dl();
    push_word(16'hBEEF, 26'd5);
    n_run++; if (sd.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL lat_e0 req got %b want 0", sd.sdram_wr_req); end
    tick();
    n_run++; if (sd.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL lat_e1 req got %b want 0", sd.sdram_wr_req); end
    tick();
    n_run++; if (sd.sdram_wr_req !== 1'b1) begin n_fail++; $display("FAIL lat_e2 req got %b want 1", sd.sdram_wr_req); end
    n_run++; if (sd.sdram_addr !== 25'hA) begin n_fail++; $display("FAIL single_addr got %h want a", sd.sdram_addr); end
    n_run++; if ({sd.sdram_addr, sd.sdram_data} !== sb[0]) begin n_fail++; $display("FAIL single_word got %h want %h", {sd.sdram_addr, sd.sdram_data}, sb[0]); end
    sd.sdram_wr_ack = 1'b1;
    tick();
    sd.sdram_wr_ack = 1'b0;
    void'(sb.pop_front());
    m_occ--;
    n_run++; if (sd.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_drop got %b want 0", sd.sdram_wr_req); end
    n_run++; if (words_written !== 24'd1) begin n_fail++; $display("FAIL single_words got %0d want 1", words_written); end
    image_download = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (download_done === 1'b1) dones++;
    end
    n_run++; if (dones != 1) begin n_fail++; $display("FAIL single_done pulses got %0d want 1", dones); end
  endtask

  task automatic test_stall();
    bit             to;
    logic [AW-1:0]  a;
    logic [15:0]    d;
    int             extra;
    start_dl();
    for (int i = 0; i < 5; i++) begin
      push_word(16'h1000 + 16'(i), 26'(100 + i));
      if (i == 1) begin
        n_run++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL stall_wait2 got %b want 0", ioctl_wait); end
      end
      if (i == 2) begin
        n_run++; if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL stall_wait3 got %b want 1", ioctl_wait); end
      end
      if (i == 3) begin
        n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stall_ovf4 got %b want 0", overflow); end
      end
    end
    n_run++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL stall_ovf5 got %b want 1", overflow); end
    for (int c = 0; c < 20; c++) begin
      n_run++;
      if (sd.sdram_wr_req !== 1'b1 || {sd.sdram_addr, sd.sdram_data} !== sb[0]) begin
        n_fail++;
        $display("FAIL stall_stable cyc %0d got req %b word %h want req 1 word %h", c, sd.sdram_wr_req, {sd.sdram_addr, sd.sdram_data}, sb[0]);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      service(0, to, a, d);
      n_run++;
      if (to || sb.size() == 0 || {a, d} !== sb[0]) begin
        n_fail++;
        $display("FAIL stall_drain %0d got %h timeout %b want %h", i, {a, d}, to, sb.size() ? sb[0] : '0);
      end
      if (sb.size() != 0) void'(sb.pop_front());
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      if (sd.sdram_wr_req === 1'b1) extra++;
      tick();
    end
    n_run++; if (extra != 0) begin n_fail++; $display("FAIL stall_extra_req got %0d cycles want 0", extra); end
    n_run++; if (words_written !== 24'd4) begin n_fail++; $display("FAIL stall_words got %0d want 4", words_written); end
    n_run++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL stall_wait_end got %b want 0", ioctl_wait); end
    n_run++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL stall_ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_stream();
    int          sent;
    int          got;
    logic [15:0] exp_sum;
    logic [15:0] d;
    start_dl();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 2000 && got < 64; cyc++) begin
      sd.sdram_wr_ack = 1'b0;
      if (sd.sdram_wr_req === 1'b1) begin
        n_run++;
        if (sb.size() == 0 || {sd.sdram_addr, sd.sdram_data} !== sb[0] || sd.sdram_addr !== AW'(got * 2)) begin
          n_fail++;
          $display("FAIL stream_word %0d got %h want addr %h", got, {sd.sdram_addr, sd.sdram_data}, AW'(got * 2));
        end
        if (sb.size() != 0) void'(sb.pop_front());
        m_occ--;
        got++;
        sd.sdram_wr_ack = 1'b1;
      end
      if (ioctl_wait === 1'b0 && sent < 64) begin
        d          = 16'($urandom);
        ioctl_wr   = 1'b1;
        ioctl_dout = d;
        base_addr  = 26'(sent);
        model_push(d, 26'(sent));
        sent++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr        = 1'b0;
    sd.sdram_wr_ack = 1'b0;
    tick();
`ifdef IMAGE_WRITER_CHECKSUM_EN
    exp_sum = m_sum;
`else
    exp_sum = 16'h0000;
`endif
    n_run++; if (got != 64) begin n_fail++; $display("FAIL stream_timeout got %0d want 64", got); end
    n_run++; if (words_written !== 24'd64) begin n_fail++; $display("FAIL stream_words got %0d want 64", words_written); end
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL stream_ovf got %b want 0", overflow); end
    n_run++; if (checksum !== exp_sum) begin n_fail++; $display("FAIL stream_csum got %h want %h", checksum, exp_sum); end
  endtask

  task automatic test_boundary();
    bit            to;
    logic [AW-1:0] a;
    logic [15:0]   d;
    start_dl();
    for (int i = 0; i < 3; i++) push_word(16'h2000 + 16'(i), 26'(200 + i));
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sd.sdram_wr_req === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    n_run++;
    if (to || {sd.sdram_addr, sd.sdram_data} !== sb[0]) begin
      n_fail++;
      $display("FAIL bnd_head got %h timeout %b want %h", {sd.sdram_addr, sd.sdram_data}, to, sb[0]);
    end
    void'(sb.pop_front());
    m_occ--;
    sd.sdram_wr_ack = 1'b1;
    ioctl_wr        = 1'b1;
    ioctl_dout      = 16'h2003;
    base_addr       = 26'd203;
    model_push(16'h2003, 26'd203);
    tick();
    ioctl_wr        = 1'b0;
    sd.sdram_wr_ack = 1'b0;
    n_run++; if (ioctl_wait !== 1'b1) begin n_fail++; $display("FAIL bnd_occ3_wait got %b want 1", ioctl_wait); end
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bnd_ovf_same got %b want 0", overflow); end
    push_word(16'h2004, 26'd204);
    n_run++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bnd_ovf_fill got %b want 0", overflow); end
    push_word(16'h2005, 26'd205);
    n_run++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bnd_ovf_drop got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      service(1, to, a, d);
      n_run++;
      if (to || sb.size() == 0 || {a, d} !== sb[0]) begin
        n_fail++;
        $display("FAIL bnd_drain %0d got %h timeout %b want %h", i, {a, d}, to, sb.size() ? sb[0] : '0);
      end
      if (sb.size() != 0) void'(sb.pop_front());
    end
    n_run++; if (words_written !== 24'd5) begin n_fail++; $display("FAIL bnd_words got %0d want 5", words_written); end
  endtask

  task automatic test_reset_mid();
    bit            to;
    logic [AW-1:0] a;
    logic [15:0]   d;
    int            reqs;
    start_dl();
    push_word(16'h3333, 26'd7);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sd.sdram_wr_req === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    n_run++; if (to) begin n_fail++; $display("FAIL rmid_req_timeout got none want req"); end
    #2;
    reset_n = 1'b0;
    #1;
    n_run++; if (sd.sdram_wr_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_async got %b want 0", sd.sdram_wr_req); end
    n_run++; if (sd.sdram_addr !== '0) begin n_fail++; $display("FAIL rmid_addr got %h want 0", sd.sdram_addr); end
    sb.delete();
    m_occ = 0;
    m_sum = '0;
    #3;
    reset_n = 1'b1;
    tick();
    n_run++; if (ioctl_wait !== 1'b0) begin n_fail++; $display("FAIL rmid_wait got %b want 0", ioctl_wait); end
    sd.sdram_wr_ack = 1'b1;
    tick();
    sd.sdram_wr_ack = 1'b0;
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      if (sd.sdram_wr_req === 1'b1) reqs++;
      tick();
    end
    n_run++; if (reqs != 0) begin n_fail++; $display("FAIL rmid_empty req cycles got %0d want 0", reqs); end
    n_run++; if (words_written !== 24'd0) begin n_fail++; $display("FAIL rmid_ack_ignored got %0d want 0", words_written); end
    push_word(16'h4444, 26'd9);
    service(0, to, a, d);
    n_run++;
    if (to || {a, d} !== sb[0]) begin
      n_fail++;
      $display("FAIL rmid_after got %h timeout %b want %h", {a, d}, to, sb[0]);
    end
    void'(sb.pop_front());
    n_run++; if (words_written !== 24'd1) begin n_fail++; $display("FAIL rmid_words got %0d want 1", words_written); end
  endtask

  task automatic test_checksum();
    bit            to;
    logic [AW-1:0] a;
    logic [15:0]   d;
    logic [15:0]   exp_sum;
    start_dl();
    push_word(16'hFFFF, 26'd0);
    service(0, to, a, d);
    n_run++; if (to || {a, d} !== sb[0]) begin n_fail++; $display("FAIL csum_w0 got %h want %h", {a, d}, sb[0]); end
    void'(sb.pop_front());
    push_word(16'h0002, 26'd1);
    service(0, to, a, d);
    n_run++; if (to || {a, d} !== sb[0]) begin n_fail++; $display("FAIL csum_w1 got %h want %h", {a, d}, sb[0]); end
    void'(sb.pop_front());
`ifdef IMAGE_WRITER_CHECKSUM_EN
    exp_sum = 16'h0001;
`else
    exp_sum = 16'h0000;
`endif
    n_run++; if (checksum !== exp_sum) begin n_fail++; $display("FAIL csum_value got %h want %h", checksum, exp_sum); end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_stall();
    test_stream();
    test_boundary();
    test_reset_mid();
    test_checksum();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/image_sdram_writer.md
IMAGE_SDRAM_WRITER -- requirements
Module: image_sdram_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries in the word FIFO; power of two, range 2..16.
REQ-002 Parameter ADDR_W, default 25, SDRAM byte-address width.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 ioctl_wr  input  1  download word strobe, one cycle per word.
REQ-006 ioctl_dout  input  16  download word data.
REQ-007 image_download  input  1  high while the current word belongs to the image region.
REQ-008 base_addr  input  26  word offset within the image region.
REQ-009 ioctl_wait  output  1  backpressure to the download source.
REQ-010 sdram_wr_req  output  1  SDRAM write request, level.
REQ-011 sdram_addr  output  ADDR_W  SDRAM byte address, equal to base_addr shifted left by 1 and truncated.
REQ-012 sdram_data  output  16  SDRAM write data.
REQ-013 sdram_wr_ack  input  1  single-cycle write-complete pulse from the SDRAM controller.
REQ-014 download_done  output  1  single-cycle pulse when the image is fully committed.
REQ-015 overflow  output  1  sticky flag: a word was dropped.
REQ-016 words_written  output  24  count of acknowledged SDRAM writes.
REQ-017 checksum  output  16  additive checksum of accepted words (see Configuration).

Function
REQ-018 Push: on a clk edge with ioctl_wr=1, image_download=1 and the FIFO not full, the block SHALL store {address, data} in the FIFO.
REQ-019 Drop: a push attempted while full SHALL discard the word and set overflow; FIFO contents and count SHALL be unchanged.
REQ-020 ioctl_wait SHALL be high combinationally whenever the occupancy is at least FIFO_DEPTH-1.
REQ-021 Write FSM states: IDLE, ISSUE, WAIT_ACK.
REQ-022 IDLE -> ISSUE when the FIFO is non-empty.
REQ-023 In ISSUE, the block SHALL load sdram_addr and sdram_data from the FIFO head, assert sdram_wr_req, and move to WAIT_ACK.
REQ-024 In WAIT_ACK, sdram_wr_req, sdram_addr and sdram_data SHALL be held stable until sdram_wr_ack=1.
REQ-025 On sdram_wr_ack, the block SHALL deassert sdram_wr_req, pop the head, increment words_written, and go to IDLE.
REQ-026 An ack received in any state other than WAIT_ACK SHALL be ignored.
REQ-027 Minimum latency: sdram_wr_req SHALL be high 2 cycles after the ioctl_wr sample edge; back-to-back words SHALL cost at least 3 cycles each (ack, IDLE, ISSUE).
REQ-028 Simultaneous push and pop in one cycle SHALL leave the occupancy unchanged, and both operations SHALL take effect.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; a pointer-extension bit SHALL distinguish full from empty.
REQ-030 A rising edge of image_download (registered previous value low, current value high) SHALL clear words_written, overflow and checksum and arm the done detector.
REQ-031 After a falling edge of image_download while armed, download_done SHALL pulse for 1 cycle on the first cycle in which the FIFO is empty and the FSM is IDLE; the detector then disarms.
REQ-032 words_written SHALL saturate at 24'hFFFFFF.

Reset
REQ-033 When reset_n is low, asynchronously: FIFO empty, pointers 0, FSM IDLE, sdram_wr_req=0, sdram_addr=0, sdram_data=0, download_done=0, overflow=0, words_written=0, checksum=0, done detector disarmed, edge register 0.
REQ-034 A reset asserted mid-transaction SHALL drop sdram_wr_req immediately; FIFO contents are lost.

Configuration
REQ-035 With macro IMAGE_WRITER_CHECKSUM_EN defined, checksum SHALL add each accepted (non-dropped) word mod 2^16 on its push edge.
REQ-036 Without IMAGE_WRITER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder logic SHALL be synthesized.

Verification
REQ-037 Single word: push 16'hBEEF at base_addr 5 -> req 2 cycles later with addr 25'hA and data BEEF; ack -> words_written=1; drop image_download -> one download_done pulse.
REQ-038 Stall: hold ack low 20 cycles while pushing 4 words with FIFO_DEPTH=4 -> ioctl_wait high after 3 words occupy the FIFO; the 5th push is dropped and sets overflow; req/addr/data stay stable throughout.
REQ-039 Streaming: 64 words with ack 1 cycle after each req -> words_written=64; all addresses are 0,2,...,126 in order; no overflow.
REQ-040 Boundary: push and ack in the same cycle at occupancy 3 -> occupancy stays 3; pointers wrap correctly across 0.
REQ-041 Reset in WAIT_ACK -> req is 0 immediately; after release the FIFO is empty and a later ack is ignored.
REQ-042 Checksum build: words 16'hFFFF and 16'h0002 -> checksum 16'h0001; without the macro -> 0.
